// File: rtl/tstate_seq_pkg.sv
// Shared definitions for the T-state sequencer: FSM encodings, default
// geometry reused by the control unit, and a parameter legality helper.
package tstate_seq_pkg;

   typedef enum logic {
      TS_RUN  = 1'b0,
      TS_HALT = 1'b1
   } ts_state_e;

   localparam int TS_WIDTH_DEF = 3;
   localparam int TS_LAST_DEF  = 7;

   // LAST must name a reachable, non-zero T-state for the given width.
   function automatic bit ts_last_legal(input int width, input int last);
      return (last >= 1) && (last <= (1 << width) - 1);
   endfunction

endpackage

// File: rtl/tstate_decode.sv
// Binary-to-one-hot decoder. Also used by the microcode ROM address logic,
// so it carries no sequencer-specific knowledge.
module tstate_decode #(
   parameter int WIDTH = 3,
   parameter int N     = 8
) (
   input  logic [WIDTH-1:0] bin,
   output logic [N-1:0]     onehot
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign onehot[i] = (bin == WIDTH'(i));
   end

endmodule

// File: rtl/tstate_seq.sv
// Parametrised T-state sequencer. T advances on the falling edge so control
// decode settles before the rising edge that latches the datapath. Supports
// wait-state stall, microcode early end (tclr) and halt/run at instruction
// boundaries only.
module tstate_seq
   import tstate_seq_pkg::*;
#(
   parameter int WIDTH = TS_WIDTH_DEF,
   parameter int LAST  = TS_LAST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             tclr,
   input  logic             halt_req,
   input  logic             run,
   output logic [WIDTH-1:0] T,
   output logic [LAST:0]    T_onehot,
   output logic             t_last,
   output logic             instr_done,
   output logic             halted
);

   if (!ts_last_legal(WIDTH, LAST)) begin : g_bad_last
      $error("tstate_seq: LAST must satisfy 1 <= LAST <= 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] LAST_T = WIDTH'(LAST);
   localparam logic [WIDTH-1:0] ONE_T  = WIDTH'(1);

   ts_state_e        state_q, state_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic             instr_done_q, instr_done_d;
   logic             boundary;

   // An instruction ends either at the configured last step or on request.
   assign boundary = (t_q == LAST_T) || tclr;

   // State, T and completion-pulse registers; falling-edge, async clear.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= TS_RUN;
         t_q          <= '0;
         instr_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         t_q          <= t_d;
         instr_done_q <= instr_done_d;
      end
   end

   // Next FSM state: halt only at an unstalled boundary, resume on run
   // unless halt is still being requested.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TS_RUN: begin
            if (!stall && boundary && halt_req) state_d = TS_HALT;
         end
         TS_HALT: begin
            if (run && !halt_req) state_d = TS_RUN;
         end
         default: state_d = TS_RUN;
      endcase
   end

   // Next T and completion pulse; HALTED pins T at 0 and leaves the pulse low.
   always_comb begin
      t_d          = t_q;
      instr_done_d = 1'b0;
      case (state_q)
         TS_RUN: begin
            if (stall) begin
               t_d = t_q;
            end else if (boundary) begin
               t_d          = '0;
               instr_done_d = 1'b1;
            end else begin
               t_d = t_q + ONE_T;
            end
         end
         default: t_d = '0;
      endcase
   end

   tstate_decode #(
      .WIDTH (WIDTH),
      .N     (LAST + 1)
   ) u_decode (
      .bin    (t_q),
      .onehot (T_onehot)
   );

   assign T          = t_q;
   assign t_last     = (t_q == LAST_T) || (tclr && !stall);
   assign instr_done = instr_done_q;
   assign halted     = (state_q == TS_HALT);

endmodule

// File: tb/tb_tstate_seq.sv
// Bench for tstate_seq: two instances (LAST=7 and LAST=4) share stimulus and
// are compared every falling edge against an integer reference model.
module tb_tstate_seq;

   logic       clk = 1'b1;
   logic       reset = 1'b0;
   logic       stall = 1'b0, tclr = 1'b0, halt_req = 1'b0, run = 1'b0;

   logic [2:0] t_a, t_b;
   logic [7:0] oh_a;
   logic [4:0] oh_b;
   logic       last_a, last_b, done_a, done_b, halt_a, halt_b;

   int total = 0;
   int bad   = 0;

   // reference model state per instance
   int m_t    [2];
   int m_done [2];
   int m_halt [2];
   int m_last [2] = '{7, 4};

   always #5 clk = ~clk;

   tstate_seq #(.WIDTH(3), .LAST(7)) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .tclr(tclr),
      .halt_req(halt_req), .run(run), .T(t_a), .T_onehot(oh_a),
      .t_last(last_a), .instr_done(done_a), .halted(halt_a)
   );

   tstate_seq #(.WIDTH(3), .LAST(4)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .tclr(tclr),
      .halt_req(halt_req), .run(run), .T(t_b), .T_onehot(oh_b),
      .t_last(last_b), .instr_done(done_b), .halted(halt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_t[k] = 0; m_done[k] = 0; m_halt[k] = 0;
      end
   endtask

   // One falling edge of the sequencer rules, written on integers.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (m_halt[k] != 0) begin
            m_t[k] = 0; m_done[k] = 0;
            if (run && !halt_req) m_halt[k] = 0;
         end else if (stall) begin
            m_done[k] = 0;
         end else if (m_t[k] == m_last[k] || tclr) begin
            m_t[k] = 0; m_done[k] = 1;
            if (halt_req) m_halt[k] = 1;
         end else begin
            m_t[k] = m_t[k] + 1; m_done[k] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int exp_last;
      for (int k = 0; k < 2; k++) begin
         exp_last = (m_t[k] == m_last[k] || (tclr && !stall)) ? 1 : 0;
         if (k == 0) begin
            chk({tag, ".A.T"},      32'(t_a),    32'(m_t[0]));
            chk({tag, ".A.onehot"}, 32'(oh_a),   32'(1) << m_t[0]);
            chk({tag, ".A.t_last"}, 32'(last_a), 32'(exp_last));
            chk({tag, ".A.done"},   32'(done_a), 32'(m_done[0]));
            chk({tag, ".A.halted"}, 32'(halt_a), 32'(m_halt[0]));
         end else begin
            chk({tag, ".B.T"},      32'(t_b),    32'(m_t[1]));
            chk({tag, ".B.onehot"}, 32'(oh_b),   32'(1) << m_t[1]);
            chk({tag, ".B.t_last"}, 32'(last_b), 32'(exp_last));
            chk({tag, ".B.done"},   32'(done_b), 32'(m_done[1]));
            chk({tag, ".B.halted"}, 32'(halt_b), 32'(m_halt[1]));
         end
      end
   endtask

   // Advance one falling edge, update the model, check 1 time unit later.
   task automatic tick(input string tag);
      @(negedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic s, input logic c, input logic h, input logic r);
      stall = s; tclr = c; halt_req = h; run = r;
   endtask

   initial begin
      int n;
      model_reset();

      // reset held across edges
      repeat (2) @(negedge clk);
      #1;
      check_all("reset");
      #2 reset = 1'b1;

      // free-running count, both geometries
      for (int i = 0; i < 8; i++) tick("count");

      // reach A at T=2, stall with tclr pending, then release
      n = 0;
      while (m_t[0] != 2 && n < 20) begin tick("seek2"); n++; end
      chk("reach_t2", 32'(t_a), 32'd2);
      drive(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick("stall_tclr");
      drive(0, 1, 0, 0);
      tick("tclr_release");
      drive(0, 0, 0, 0);

      // halt_req pulsed mid-instruction is not latched
      n = 0;
      while (m_t[0] != 3 && n < 20) begin tick("seek3"); n++; end
      chk("reach_t3", 32'(t_a), 32'd3);
      drive(0, 0, 1, 0);
      tick("hreq_pulse");
      drive(0, 0, 0, 0);
      tick("hreq_drop");

      // held halt_req halts at the boundary; stays halted
      drive(0, 0, 1, 0);
      n = 0;
      while (m_halt[0] == 0 && n < 20) begin tick("to_halt"); n++; end
      chk("halt_a", 32'(halt_a), 32'd1);
      drive(1, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick("halted_hold");
      drive(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) tick("run_and_hreq");
      drive(0, 0, 0, 1);
      tick("resume");
      drive(0, 0, 0, 0);
      tick("first_inc");
      tick("second_inc");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 12,
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30);
         tick("rand");
      end

      // async reset mid-instruction at A T=5
      drive(0, 0, 0, 1);
      n = 0;
      while (!(m_t[0] == 5 && m_halt[0] == 0) && n < 40) begin tick("seek5"); n++; end
      chk("reach_t5", 32'(t_a), 32'd5);
      drive(0, 0, 0, 0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      #1;
      check_all("rst_held");
      #2 reset = 1'b1;
      #1;
      check_all("rst_release");
      tick("post_rst1");
      tick("post_rst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
